// File: rtl/cpu_lsu_wb.sv
// rtl/cpu_lsu_wb.sv - load/store unit bridging pipeline requests to a Wishbone pipelined master
// Tracks in-flight transfers in a small FIFO so responses return in issue order.
module cpu_lsu_wb #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MAX_OUT = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [4:0]      req_rd,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_err,
    output logic            data_cyc_out,
    output logic            data_stb_out,
    output logic            data_we_out,
    output logic [DW/8-1:0] data_be_out,
    output logic [AW-1:0]   data_addr_out,
    output logic [DW-1:0]   data_data_out,
    input  logic            data_ack_in,
    input  logic            data_err_in,
    input  logic            data_stall_in,
    input  logic [DW-1:0]   data_data_in,
    output logic            lsu_busy,
    output logic            proto_err
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic            stb_q;
    logic [1:0]      p_size;
    logic            p_uns;
    logic [OW-1:0]   p_off;
    logic [4:0]      p_rd;

    logic            f_we   [MAX_OUT];
    logic [1:0]      f_size [MAX_OUT];
    logic            f_uns  [MAX_OUT];
    logic [OW-1:0]   f_off  [MAX_OUT];
    logic [4:0]      f_rd   [MAX_OUT];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;

    logic            illegal, misaligned, bad, idle, space;
    logic            bus_ev, pop, push, accept, issue, bad_acc;
    logic [2:0]      amask;
    logic [BW-1:0]   be_base;
    logic [CW:0]     occ;
    logic [DW-1:0]   ld_shift, ld_mask, ld_data;
    logic            ld_sgn;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        amask   = 3'b000;
        be_base = '0;
        case (req_size)
            2'd0: begin amask = 3'b000; be_base = BW'(8'h01); end
            2'd1: begin amask = 3'b001; be_base = BW'(8'h03); end
            2'd2: begin amask = 3'b011; be_base = BW'(8'h0F); end
            default: begin amask = 3'b111; be_base = BW'(8'hFF); end
        endcase
    end

    assign illegal    = (req_size == 2'd3) && (DW == 32);
    assign misaligned = |(req_addr[2:0] & amask);
    assign bad        = illegal | misaligned;

    assign bus_ev = data_ack_in | data_err_in;
    assign pop    = bus_ev & (count != '0);
    assign push   = stb_q & ~data_stall_in;
    assign idle   = (count == '0) & ~stb_q;

    // A held stb is a transfer already committed, so it counts against capacity.
    assign occ    = {1'b0, count} + (CW+1)'(stb_q) - (CW+1)'(pop);
    assign space  = occ < (CW+1)'(MAX_OUT);

    assign req_ready = sys_rst & ~(stb_q & data_stall_in) & (bad ? idle : space);
    assign accept    = req_valid & req_ready;
    assign issue     = accept & ~bad;
    assign bad_acc   = accept & bad;

    assign data_stb_out = stb_q;
    assign data_cyc_out = stb_q | (count != '0);
    assign lsu_busy     = data_cyc_out;

    always_comb begin
        ld_shift = data_data_in >> {f_off[rptr], 3'b000};
        ld_mask  = '1;
        ld_sgn   = 1'b0;
        case (f_size[rptr])
            2'd0: begin ld_mask = DW'(8'hFF);         ld_sgn = ld_shift[7];  end
            2'd1: begin ld_mask = DW'(16'hFFFF);      ld_sgn = ld_shift[15]; end
            2'd2: begin ld_mask = DW'(32'hFFFF_FFFF); ld_sgn = ld_shift[31]; end
            default: begin ld_mask = '1;              ld_sgn = 1'b0;         end
        endcase
        ld_data = (ld_shift & ld_mask) | ((~f_uns[rptr] & ld_sgn) ? ~ld_mask : '0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            stb_q         <= 1'b0;
            data_we_out   <= 1'b0;
            data_be_out   <= '0;
            data_addr_out <= '0;
            data_data_out <= '0;
            p_size        <= '0;
            p_uns         <= 1'b0;
            p_off         <= '0;
            p_rd          <= '0;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_rd        <= '0;
            rsp_err       <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            if (issue) begin
                stb_q         <= 1'b1;
                data_we_out   <= req_we;
                data_be_out   <= be_base << req_addr[OW-1:0];
                data_addr_out <= req_addr & ~AW'(BW - 1);
                data_data_out <= req_wdata << {req_addr[OW-1:0], 3'b000};
                p_size        <= req_size;
                p_uns         <= req_unsigned;
                p_off         <= req_addr[OW-1:0];
                p_rd          <= req_rd;
            end else if (push) begin
                stb_q <= 1'b0;
            end
            if (push)
                wptr <= nxt(wptr);
            if (pop)
                rptr <= nxt(rptr);
            count <= count + CW'(push) - CW'(pop);

            rsp_valid <= (pop & (data_err_in | ~f_we[rptr])) | bad_acc;
            rsp_err   <= pop ? data_err_in : bad_acc;
            rsp_data  <= (pop & ~data_err_in & ~f_we[rptr]) ? ld_data : '0;
            rsp_rd    <= pop ? f_rd[rptr] : (bad_acc ? req_rd : '0);

            if (bus_ev & (count == '0))
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            f_we[wptr]   <= data_we_out;
            f_size[wptr] <= p_size;
            f_uns[wptr]  <= p_uns;
            f_off[wptr]  <= p_off;
            f_rd[wptr]   <= p_rd;
        end
    end

endmodule

// File: doc/cpu_lsu_wb.md
CPU_LSU_WB -- requirements
Module: cpu_lsu_wb

Interface
REQ-001 Parameter DW, default 32, data bus width; legal values 32 or 64.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter MAX_OUT, default 2, maximum in-flight bus transfers; power of two, 1..8.
REQ-004 sys_clk  in  1  single clock; all state changes on rising edge.
REQ-005 sys_rst  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  pipeline memory request present.
REQ-007 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DW=64).
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  AW  byte address.
REQ-012 req_wdata  in  DW  store data, right-aligned.
REQ-013 req_rd  in  5  destination register tag for loads.
REQ-014 rsp_valid  out  1  one-cycle load or error response.
REQ-015 rsp_data  out  DW  extended load data; 0 on error.
REQ-016 rsp_rd  out  5  tag of the responding request.
REQ-017 rsp_err  out  1  misaligned or illegal-size request, or bus error.
REQ-018 data_cyc_out, data_stb_out, data_we_out  out  1 each  Wishbone pipelined master controls.
REQ-019 data_be_out  out  DW/8  byte enables.
REQ-020 data_addr_out  out  AW  lane-aligned address (low log2(DW/8) bits zero).
REQ-021 data_data_out  out  DW  lane-shifted store data.
REQ-022 data_ack_in, data_err_in, data_stall_in  in  1 each; data_data_in  in  DW.
REQ-023 lsu_busy  out  1  high while any transfer is pending or stb is held.
REQ-024 proto_err  out  1  sticky: ack/err received with zero transfers in flight.

Function
REQ-025 In-flight FIFO of depth MAX_OUT shall hold {we, size, unsigned, lane offset, rd} per issued transfer; push on stb accepted (stb & ~stall), pop on ack or err.
REQ-026 req_ready = ~(stb & stall) & (inflight count < MAX_OUT), except as limited by REQ-031.
REQ-027 Accepted aligned request shall drive stb and all bus outputs registered in the next cycle; while stall is high, stb and outputs shall stay stable.
REQ-028 data_cyc_out shall be high whenever stb is high or in-flight count > 0, and low otherwise.
REQ-029 Byte enables: size n sets 2^n consecutive bits starting at lane offset; store data shifted left by 8*offset.
REQ-030 Load ack: rsp_valid next cycle, data = bytes at stored offset, extended per stored size/unsigned; store ack produces no response.
REQ-031 Misaligned (addr mod 2^size != 0) or illegal size: req_ready held low until in-flight count = 0 and stb low; then accepted, no bus cycle, rsp_valid with rsp_err=1 and rsp_rd next cycle.
REQ-032 data_err_in pops FIFO; rsp_valid with rsp_err=1 for both loads and stores.
REQ-033 Simultaneous push and pop shall leave count unchanged; FIFO pointers wrap modulo MAX_OUT.
REQ-034 Ack or err with count = 0 shall be ignored except setting proto_err; no response.
REQ-035 Responses shall be in issue order; at most one response per cycle.

Reset
REQ-036 On sys_rst low: FIFO empty, count 0, all outputs 0 (req_ready 0), proto_err cleared; req_ready may rise in the first cycle after release.
REQ-037 Reset mid-transfer discards all in-flight entries; late acks after release set proto_err.

Verification
REQ-038 DW=32: load word addr 0x100, ack data 0xDEADBEEF, no stall -> be 4'b1111, rsp_data 0xDEADBEEF, rsp_rd matches, latency stb->rsp = ack cycle +1.
REQ-039 Signed byte load addr 0x103, bus data 0x80000000 -> be 4'b1000, rsp_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Store half 0xBEEF addr 0x202, stall high 3 cycles -> stb/addr 0x200/data 0xBEEF0000/be 4'b1100 stable 4 cycles, no rsp.
REQ-041 MAX_OUT=2: three back-to-back loads, acks delayed -> req_ready low after 2 issues, rises same cycle as first ack; responses in order.
REQ-042 Word load addr 0x101 with one transfer outstanding -> req_ready low until ack, then rsp_err=1, no stb.
REQ-043 Ack with cyc low -> proto_err=1, no rsp_valid; sys_rst low clears it.
